desc_byte_tx: RTL
=================

Name: desc_byte_tx

Overview:
- Byte-serial transmitter: the outbound counterpart of the descriptor loader's 8-bit shift-in path.
- Latches a wide descriptor/result word from the vision core on `load`, then streams it to the PCI-side byte channel.
- Frame format: one header byte, then W/8 payload bytes MSB-first, using a valid/ready handshake.
- MSB-first order matches the receiver, which shifts left by 8 per byte, so the first byte sent lands in the top byte.

Parameters:
- W, 2048: payload width in bits; must be a multiple of 8 and ≥ 16.
- HEADER, 8'hA5: constant start-of-frame byte sent before the payload.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load  in  1  start request; sampled only when busy=0
- data_in  in  W  word to send; captured on an accepted load
- abort  in  1  synchronous frame cancel
- busy  out  1  high while a frame is in progress
- out_byte  out  8  byte on the channel
- out_valid  out  1  out_byte is valid
- out_ready  in  1  sink accepts out_byte this cycle
- done  out  1  one-cycle pulse when a frame completes normally

Behaviour:
- Reset: asynchronous, active-high, clock clk. All outputs go to 0, state→IDLE, shift register and counter cleared. This applies mid-frame too; no done is produced for the interrupted frame.
- A transfer occurs on any cycle with out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_byte and out_valid hold stable. out_valid never drops without a transfer, except on abort or rst.
- State IDLE:
  - busy=0, out_valid=0.
  - load=1 → capture data_in into a W-bit shift register, clear byte counter, go to HDR.
  - Latency: out_valid=1 with HEADER on the cycle after load.
- State HDR:
  - out_byte=HEADER.
  - On transfer → PAY, out_byte=sreg[W-1:W-8].
- State PAY:
  - out_byte=sreg[W-1:W-8].
  - On transfer: sreg<<=8 (zero fill), count++.
  - When the transfer is of byte W/8−1 (count==W/8−1): go to CSUM if enabled, otherwise go to IDLE and pulse done.
- Byte counter: width $clog2(W/8+1); no wrap within a frame.
- done and busy:
  - done is registered and high for exactly the one cycle after the final transfer; in that cycle state=IDLE and busy=0.
  - A load on that same cycle is accepted, giving back-to-back frames with one idle cycle of out_valid between them.
- load while busy=1 is ignored; captured data is not modified.
- abort=1 in any non-IDLE state: next cycle state=IDLE, out_valid=0, no done. Abort takes priority over a simultaneous transfer.
- abort in IDLE has no effect. If abort and load are asserted together in IDLE, load wins.
- Throughput: one byte per cycle with out_ready held high. Frame time is W/8+1 cycles (+1 with checksum).

Optional Feature:
- Macro: DESC_TX_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR accumulator is cleared on load and XORs every payload byte at transfer (the header is excluded).
  - After the last payload byte the FSM enters CSUM: out_byte=accumulator, held until transfer, then IDLE plus done.
  - Frame length is W/8+2 bytes.
- When undefined: no CSUM state and no accumulator logic; frame length is W/8+1 bytes.

Test Plan:
- Basic frame: W=32, load with data_in=32'h12345678, out_ready=1 → bytes A5,12,34,56,78 on consecutive cycles. done pulses the cycle after 78; busy high from load+1 through the 78 cycle.
- Checksum: same stimulus with DESC_TX_CHECKSUM_EN → bytes A5,12,34,56,78,08, then done.
- Backpressure: out_ready=0 for 3 cycles while byte 34 is presented → out_byte=34 and out_valid=1 held stable for those 3 cycles. The sequence then resumes unchanged; done is delayed by 3 cycles.
- Load while busy: second load with data_in=32'hDEADBEEF mid-frame → ignored, frame still 12,34,56,78. A load on the done cycle with 32'hCAFEF00D → next frame A5,CA,FE,F0,0D.
- Abort: abort asserted while byte 56 is presented → next cycle out_valid=0, busy=0, no done. A subsequent load sends a full fresh frame.
- Reset: rst asserted asynchronously mid-payload → out_valid, busy, done and out_byte all 0 immediately. After release, the FSM is in IDLE and a fresh load produces the correct frame.

Source files
------------

// File: rtl/desc_byte_tx_if.sv
// Descriptor byte-transmitter port bundle: load side and byte channel.
// master is the transmitter's view; slave is the driver/sink view.
interface desc_byte_tx_if #(
  parameter int unsigned W = 2048
);
  logic         load;
  logic [W-1:0] data_in;
  logic         abort;
  logic         busy;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         done;

  modport master (
    input  load, data_in, abort, out_ready,
    output busy, out_byte, out_valid, done
  );

  modport slave (
    output load, data_in, abort, out_ready,
    input  busy, out_byte, out_valid, done
  );
endinterface

// File: rtl/desc_byte_tx.sv
// Byte-serial descriptor transmitter: HEADER byte then W/8 payload bytes MSB-first.
// Optional trailing XOR checksum byte when DESC_TX_CHECKSUM_EN is defined.
module desc_byte_tx #(
  parameter int unsigned W      = 2048,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input logic            clk,
  input logic            rst,
  desc_byte_tx_if.master bus
);

  localparam int unsigned NBytes = W / 8;
  localparam int unsigned CntW   = $clog2(NBytes + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

`ifdef DESC_TX_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StHdr, StPay, StCsum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;
`endif

  state_e          state_q, state_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            valid;
  logic            xfer;
`ifdef DESC_TX_CHECKSUM_EN
  logic [7:0]      acc_q, acc_d;
`endif

  assign valid = (state_q != StIdle);
  assign xfer  = valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef DESC_TX_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Load wins over a simultaneous abort; abort has no meaning here.
        if (bus.load) begin
          sreg_d  = bus.data_in;
          cnt_d   = '0;
`ifdef DESC_TX_CHECKSUM_EN
          acc_d   = '0;
`endif
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (xfer) begin
          state_d = StPay;
        end
      end
      StPay: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (xfer) begin
          sreg_d = sreg_q << 8;
          cnt_d  = cnt_q + 1'b1;
`ifdef DESC_TX_CHECKSUM_EN
          acc_d  = acc_q ^ sreg_q[W-1 -: 8];
`endif
          if (cnt_q == LastCnt) begin
`ifdef DESC_TX_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StIdle;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef DESC_TX_CHECKSUM_EN
      StCsum: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (xfer) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef DESC_TX_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  always_comb begin
    bus.out_byte = 8'h00;
    unique case (state_q)
      StIdle:  bus.out_byte = 8'h00;
      StHdr:   bus.out_byte = HEADER;
      StPay:   bus.out_byte = sreg_q[W-1 -: 8];
`ifdef DESC_TX_CHECKSUM_EN
      StCsum:  bus.out_byte = acc_q;
`endif
      default: bus.out_byte = 8'h00;
    endcase
  end

  assign bus.out_valid = valid;
  assign bus.busy      = valid;
  assign bus.done      = done_q;

endmodule
